// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, instruction memory, IF/ID register
// Adds program load, stall, jump-with-squash and halt-word detection to a plain fetch stage.
module instruction_fetch_unit #(
  parameter int                      INSTR_WIDTH = 32,
  parameter int                      PC_WIDTH    = 32,
  parameter int                      MEM_DEPTH   = 256,
  parameter logic [PC_WIDTH-1:0]     PC_STEP     = PC_WIDTH'(4),
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = INSTR_WIDTH'(32'hFFFF_FFFF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   wr_en,
  input  logic [PC_WIDTH-1:0]    wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_next_seq,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid,
  output logic                   halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t                 state, state_nx;
  logic [PC_WIDTH-1:0]    fa, fa_nx;
  logic [PC_WIDTH-1:0]    pc_nx;
  logic [INSTR_WIDTH-1:0] instr_nx;
  logic [INSTR_WIDTH-1:0] rd_word;
  logic                   valid_nx;
  logic                   mem_we;

  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte address to word index; upper and byte-offset bits fall away so addresses wrap.
  function automatic logic [AW-1:0] word_index(input logic [PC_WIDTH-1:0] addr);
    return AW'(addr >> 2);
  endfunction

  assign rd_word     = mem[word_index(fa)];
  assign pc_next_seq = pc + PC_STEP;
  assign halted      = (state == S_HALT);

  always_comb begin
    state_nx = state;
    fa_nx    = fa;
    pc_nx    = pc;
    instr_nx = instruction;
    valid_nx = valid;
    mem_we   = 1'b0;
    case (state)
      S_LOAD: begin
        fa_nx    = RESET_PC;
        valid_nx = 1'b0;
        if (start) begin
          state_nx = S_RUN;
        end else begin
          mem_we = wr_en;
        end
      end
      S_RUN: begin
        if (!start) begin
          state_nx = S_LOAD;
          valid_nx = 1'b0;
          fa_nx    = RESET_PC;
        end else if (jump) begin
          // Squash the wrong-path word but keep pc/instruction for the consumer.
          fa_nx    = jump_target;
          valid_nx = 1'b0;
        end else if (!stall) begin
          instr_nx = rd_word;
          pc_nx    = fa;
          valid_nx = 1'b1;
          fa_nx    = fa + PC_STEP;
          if (rd_word == HALT_WORD) begin
            state_nx = S_HALT;
          end
        end
      end
      S_HALT: begin
        valid_nx = 1'b0;
        if (!start) begin
          state_nx = S_LOAD;
          fa_nx    = RESET_PC;
        end
      end
      default: begin
        state_nx = S_LOAD;
        fa_nx    = RESET_PC;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_LOAD;
      fa          <= RESET_PC;
      pc          <= RESET_PC;
      instruction <= '0;
      valid       <= 1'b0;
    end else begin
      state       <= state_nx;
      fa          <= fa_nx;
      pc          <= pc_nx;
      instruction <= instr_nx;
      valid       <= valid_nx;
    end
  end

  // Memory is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_index(wr_addr)] <= wr_data;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Parametrised instruction-fetch stage for the MIPS pipeline. It holds the program counter, the on-chip instruction memory and the IF/ID output register. It adds three modes over a plain fetch stage: program loading, stall, and jump with squash. It also detects a programmable halt word and stops fetching when it sees it.

## Interface
Parameters:
- INSTR_WIDTH, 32, instruction word width
- PC_WIDTH, 32, program counter width
- MEM_DEPTH, 256, instruction memory depth in words (power of two, ≥2)
- PC_STEP, 4, byte increment per sequential fetch
- RESET_PC, 0, PC value after reset and on entering LOAD
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  1 = run program, 0 = load mode
- wr_en  in  1  memory write strobe (honoured in LOAD only)
- wr_addr  in  PC_WIDTH  byte address of word to write
- wr_data  in  INSTR_WIDTH  instruction to write
- stall  in  1  hold PC and output register (hazard from ID)
- jump  in  1  redirect fetch to jump_target
- jump_target  in  PC_WIDTH  redirect byte address
- pc  out  PC_WIDTH  address of the instruction on `instruction`
- pc_next_seq  out  PC_WIDTH  pc + PC_STEP (link address)
- instruction  out  INSTR_WIDTH  fetched word
- valid  out  1  instruction/pc pair is a real, non-squashed fetch
- halted  out  1  unit is in HALT

## Operation
- Internal fetch address `fa` (PC_WIDTH). Word index = fa[log2(MEM_DEPTH)+1:2]. Upper bits and low 2 bits are ignored, so addresses wrap modulo MEM_DEPTH words. wr_addr is indexed the same way.
- The memory has no reset. Contents persist across reset.
- Arithmetic: pc + PC_STEP and fa + PC_STEP are modulo 2^PC_WIDTH.
- States: LOAD, RUN, HALT. The reset state is LOAD.
- LOAD:
  - fa = RESET_PC, valid = 0.
  - wr_en = 1 writes wr_data to mem[index(wr_addr)] at the edge.
  - start = 1 → RUN on the next edge. No write occurs on that edge, even if wr_en = 1.
- RUN: evaluate in priority order each edge.
  1. start = 0 → LOAD. Set valid ← 0 and fa ← RESET_PC.
  2. jump = 1 (overrides stall) → fa ← jump_target and valid ← 0 (squash the wrong-path word). pc and instruction hold their values.
  3. stall = 1 → everything holds.
  4. Otherwise:
     - instruction ← mem[index(fa)], pc ← fa, valid ← 1, fa ← fa + PC_STEP.
     - If the word read equals HALT_WORD, it is still output with valid = 1, and the state becomes HALT.
- wr_en is ignored in RUN and HALT.
- HALT:
  - halted = 1; fa, pc and instruction are frozen.
  - valid drops to 0 one cycle after entry.
  - jump and stall are ignored.
  - start = 0 → LOAD (fa ← RESET_PC, halted ← 0).
- pc_next_seq = pc + PC_STEP, combinational from the pc register.

## Timing
- Reset asserted (asynchronous): state = LOAD, fa = RESET_PC, pc = RESET_PC, instruction = 0, valid = 0, halted = 0. pc_next_seq = RESET_PC + PC_STEP.
- Reset mid-RUN or mid-HALT: outputs take their reset values immediately. Memory contents are kept.
- Fetch latency: 1 cycle from fa to the registered instruction/pc. The first valid output appears 2 edges after start rises in LOAD (edge 1: LOAD→RUN; edge 2: first fetch).
- Jump: the edge with jump = 1 gives valid = 0. The next unstalled edge outputs mem[jump_target] with pc = jump_target. One bubble per jump.
- Jump and stall asserted together: the jump is taken.
- Halt: the HALT_WORD appears with valid = 1 on edge N. halted = 1 from edge N. valid = 0 from edge N+1.

## Test plan
- Load, then run:
  - Stimulus: load mem[0..3] = 0x11, 0x22, 0x33, HALT_WORD; start = 1.
  - Required response: valid pairs (pc, instruction) = (0, 0x11), (4, 0x22), (8, 0x33), (12, HALT_WORD). halted = 1 on the same edge as the last pair; valid = 0 on the next.
- Stall:
  - Stimulus: stall = 1 for 3 cycles while pc = 4.
  - Required response: pc = 4, instruction = 0x22 and valid = 1 held for all 3 cycles. pc = 8 on the first edge after stall drops.
- Jump:
  - Stimulus: jump = 1 with jump_target = 0x10 and stall = 1, with mem[4] = 0xAB.
  - Required response: valid = 0 on the next edge, then (pc, instruction) = (0x10, 0xAB) with valid = 1.
- Wrap:
  - Stimulus: MEM_DEPTH = 4, jump_target = 0x1C.
  - Required response: fetch returns the word written at mem[3] (address 0x0C). The next fetch has pc = 0x20 and returns mem[0].
- Mode and write-ignore:
  - Stimulus: wr_en = 1 to address 0 during RUN.
  - Required response: mem[0] is unchanged.
  - Stimulus: start dropped in RUN.
  - Required response: valid = 0 and fa = RESET_PC; the re-run restarts from 0.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges during RUN.
  - Required response: valid = 0, halted = 0 and pc = RESET_PC immediately. After release, the unit stays in LOAD while start = 0, and the memory still holds the program.
